// File: rtl/mc_if.sv
// Control bundle between the multicycle controller and its datapath:
// decoded IR fields and flags in, write enables and mux selects out.
interface mc_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_we;
  logic        ir_we;
  logic        reg_we;
  logic        mem_we;
  logic [2:0]  alu_op;
  logic        alu_src_b;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        ext_op;
  logic [1:0]  npc_sel;
  logic [2:0]  state;
  logic        instr_done;
  logic [31:0] instr_cnt;

  modport master (
    output op, funct, zero,
    input  pc_we, ir_we, reg_we, mem_we, alu_op, alu_src_b, reg_dst, wd_sel,
           ext_op, npc_sel, state, instr_done, instr_cnt
  );

  modport slave (
    input  op, funct, zero,
    output pc_we, ir_we, reg_we, mem_we, alu_op, alu_src_b, reg_dst, wd_sel,
           ext_op, npc_sel, state, instr_done, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle controller for a small MIPS subset: IF/ID/EX/MEM/WB FSM with
// combinational control decode and a retired-instruction counter.
module mc_ctrl (
  input  logic clk,
  input  logic reset,
  mc_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  logic [2:0]  state_q;
  state_e      state_d;
  logic [31:0] instr_cnt_q;
  logic [31:0] instr_cnt_d;

  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, needs_ex;

  logic       pc_we, ir_we, reg_we, mem_we, instr_done;
  logic       alu_src_b, ext_op;
  logic [2:0] alu_op;
  logic [1:0] reg_dst, wd_sel, npc_sel;

  always_comb begin
    is_rtype = (bus.op == 6'b000000);
    is_addu  = is_rtype && (bus.funct == 6'b100001);
    is_subu  = is_rtype && (bus.funct == 6'b100011);
    is_jr    = is_rtype && (bus.funct == 6'b001000);
    is_ori   = (bus.op == 6'b001101);
    is_lui   = (bus.op == 6'b001111);
    is_lw    = (bus.op == 6'b100011);
    is_sw    = (bus.op == 6'b101011);
    is_beq   = (bus.op == 6'b000100);
    is_j     = (bus.op == 6'b000010);
    is_jal   = (bus.op == 6'b000011);
    needs_ex = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
  end

  always_comb begin
    state_d   = S_IF;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    npc_sel   = 2'b00;
    ext_op    = is_lw | is_sw | is_beq;
    alu_src_b = is_ori | is_lui | is_lw | is_sw;
    if (is_subu || is_beq)  alu_op = 3'b001;
    else if (is_ori)        alu_op = 3'b010;
    else if (is_lui)        alu_op = 3'b011;
    else                    alu_op = 3'b000;

    case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          pc_we   = 1'b1;
          npc_sel = 2'b10;
        end else if (is_jal) begin
          pc_we   = 1'b1;
          npc_sel = 2'b10;
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          npc_sel = 2'b11;
        end else if (needs_ex) begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_beq) begin
          pc_we   = bus.zero;
          npc_sel = 2'b01;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_addu || is_subu || is_ori || is_lui) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw)      mem_we  = 1'b1;
        else if (is_lw) state_d = S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = (is_addu || is_subu) ? 2'b01 : 2'b00;
        wd_sel  = is_lw ? 2'b01 : 2'b00;
      end
      default: state_d = S_IF;
    endcase

    instr_done = (state_d == S_IF);

    // Reset must suppress every side effect even while the FSM still shows an old state.
    if (!reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
    end

    instr_cnt_d = instr_cnt_q + {31'd0, instr_done};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IF;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.ir_we      = ir_we;
  assign bus.reg_we     = reg_we;
  assign bus.mem_we     = mem_we;
  assign bus.alu_op     = alu_op;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.reg_dst    = reg_dst;
  assign bus.wd_sel     = wd_sel;
  assign bus.ext_op     = ext_op;
  assign bus.npc_sel    = npc_sel;
  assign bus.state      = state_q;
  assign bus.instr_done = instr_done;
  assign bus.instr_cnt  = instr_cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instructions checked per cycle
// against a reference built from per-instruction state paths.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset;
  mc_if bus();

  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_cnt;
  logic [18:0] obs_q[$];
  logic [31:0] cnt_q[$];

  typedef enum int {K_ADDU, K_SUBU, K_JR, K_NOP, K_ORI, K_LUI, K_LW, K_SW,
                    K_BEQ, K_J, K_JAL} kind_e;

  // {op, funct} for each decoded instruction
  logic [11:0] legal_tab [0:10] = '{
    {6'b000000, 6'b100001}, {6'b000000, 6'b100011}, {6'b000000, 6'b001000},
    {6'b000000, 6'b000000}, {6'b001101, 6'b000000}, {6'b001111, 6'b000000},
    {6'b100011, 6'b000000}, {6'b101011, 6'b000000}, {6'b000100, 6'b000000},
    {6'b000010, 6'b000000}, {6'b000011, 6'b000000}};

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'b000000: begin
        if (f == 6'b100001) return K_ADDU;
        if (f == 6'b100011) return K_SUBU;
        if (f == 6'b001000) return K_JR;
        return K_NOP;
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic int cpi(input kind_e k);
    case (k)
      K_LW:                        return 5;
      K_BEQ:                       return 3;
      K_J, K_JAL, K_JR, K_NOP:     return 2;
      default:                     return 4;
    endcase
  endfunction

  // Ordered states visited by one instruction.
  function automatic logic [2:0] path_state(input kind_e k, input int p);
    logic [2:0] path [$];
    path = '{3'd0, 3'd1};
    if (cpi(k) >= 3) path.push_back(3'd2);
    if (k == K_LW || k == K_SW) path.push_back(3'd3);
    if (k == K_LW || k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI)
      path.push_back(3'd4);
    return path[p];
  endfunction

  // {state, pc_we, ir_we, reg_we, mem_we, alu_op, alu_src_b, reg_dst, wd_sel, ext_op, npc_sel, instr_done}
  function automatic logic [18:0] expect_out(input kind_e k, input int p, input logic z);
    logic [2:0] st, alu;
    logic       pc, ir, rw, mw, asb, ext, done;
    logic [1:0] rd, wd, npc;
    st = path_state(k, p);
    {pc, ir, rw, mw} = 4'b0000;
    rd = 2'b00; wd = 2'b00; npc = 2'b00;
    done = (p == cpi(k) - 1);
    alu = (k == K_SUBU || k == K_BEQ) ? 3'b001 : (k == K_ORI) ? 3'b010 :
          (k == K_LUI) ? 3'b011 : 3'b000;
    asb = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
    ext = (k == K_LW || k == K_SW || k == K_BEQ);
    if (st == 3'd0) begin ir = 1'b1; pc = 1'b1; end
    if (st == 3'd1 && k == K_J)   begin pc = 1'b1; npc = 2'b10; end
    if (st == 3'd1 && k == K_JAL) begin pc = 1'b1; npc = 2'b10; rw = 1'b1; rd = 2'b10; wd = 2'b10; end
    if (st == 3'd1 && k == K_JR)  begin pc = 1'b1; npc = 2'b11; end
    if (st == 3'd2 && k == K_BEQ) begin pc = z; npc = 2'b01; end
    if (st == 3'd3 && k == K_SW)  mw = 1'b1;
    if (st == 3'd4) begin
      rw = 1'b1;
      rd = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
      wd = (k == K_LW) ? 2'b01 : 2'b00;
    end
    return {st, pc, ir, rw, mw, alu, asb, rd, wd, ext, npc, done};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.state, bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we, bus.alu_op,
            bus.alu_src_b, bus.reg_dst, bus.wd_sel, bus.ext_op, bus.npc_sel, bus.instr_done};
  endfunction

  // Drive an instruction and record n cycle samples, one per cycle after the falling edge.
  task automatic capture(input logic [5:0] op, input logic [5:0] f, input logic z, input int n);
    obs_q.delete();
    cnt_q.delete();
    bus.op = op; bus.funct = f; bus.zero = z;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      obs_q.push_back(observed());
      cnt_q.push_back(bus.instr_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op = 6'b100011; bus.funct = 6'b000000; bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.state);
    else n_pass++;
    n_chk++;
    if (bus.instr_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", bus.instr_cnt);
    else n_pass++;
    n_chk++;
    if ({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we, bus.instr_done} !== 5'b00000)
      $display("FAIL reset_we: got %b want 00000",
               {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we, bus.instr_done});
    else n_pass++;
    reset = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_ori();
    kind_e k;
    k = K_ORI;
    capture(6'b001101, 6'b000000, 1'b0, 5);
    for (int p = 0; p < 4; p++) begin
      n_chk++;
      if (obs_q[p] !== expect_out(k, p, 1'b0))
        $display("FAIL ori_cycle%0d: got %b want %b", p, obs_q[p], expect_out(k, p, 1'b0));
      else n_pass++;
    end
    exp_cnt = exp_cnt + 32'd1;
    n_chk++;
    if (obs_q[4][18:16] !== 3'd0 || cnt_q[4] !== exp_cnt)
      $display("FAIL ori_retire: state %0d cnt %0d want state 0 cnt %0d", obs_q[4][18:16], cnt_q[4], exp_cnt);
    else n_pass++;
  endtask

  task automatic run_checked(input string tag, input logic [5:0] op, input logic [5:0] f, input logic z);
    kind_e k;
    int    n;
    k = classify(op, f);
    n = cpi(k);
    capture(op, f, z, n + 1);
    for (int p = 0; p < n; p++) begin
      n_chk++;
      if (obs_q[p] !== expect_out(k, p, z))
        $display("FAIL %s_cycle%0d: got %b want %b", tag, p, obs_q[p], expect_out(k, p, z));
      else n_pass++;
    end
    exp_cnt = exp_cnt + 32'd1;
    n_chk++;
    if (obs_q[n][18:16] !== 3'd0 || cnt_q[n] !== exp_cnt)
      $display("FAIL %s_retire: state %0d cnt %0d want state 0 cnt %0d", tag, obs_q[n][18:16], cnt_q[n], exp_cnt);
    else n_pass++;
  endtask

  task automatic test_lw_sw();
    run_checked("lw", 6'b100011, 6'b010101, 1'b1);
    run_checked("sw", 6'b101011, 6'b000000, 1'b0);
  endtask

  task automatic test_beq();
    run_checked("beq_taken", 6'b000100, 6'b000000, 1'b1);
    run_checked("beq_not_taken", 6'b000100, 6'b000000, 1'b0);
  endtask

  task automatic test_jal();
    run_checked("jal", 6'b000011, 6'b111111, 1'b0);
  endtask

  task automatic test_misc_ops();
    run_checked("unknown_op", 6'b111111, 6'b100001, 1'b1);
    run_checked("j", 6'b000010, 6'b000000, 1'b0);
    run_checked("jr", 6'b000000, 6'b001000, 1'b0);
    run_checked("nop", 6'b000000, 6'b000000, 1'b0);
    run_checked("addu", 6'b000000, 6'b100001, 1'b0);
    run_checked("subu", 6'b000000, 6'b100011, 1'b1);
    run_checked("lui", 6'b001111, 6'b000000, 1'b0);
    run_checked("bad_funct", 6'b000000, 6'b101010, 1'b0);
  endtask

  task automatic test_random();
    logic [11:0] pick;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) != 0) pick = legal_tab[$urandom_range(10)];
      else                        pick = 12'($urandom);
      run_checked("random", pick[11:6], pick[5:0], 1'($urandom));
    end
  endtask

  task automatic test_illegal_state();
    bus.op = 6'b000000; bus.funct = 6'b000000; bus.zero = 1'b0;
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    #1;
    n_chk++;
    if (observed() !== {3'd6, 4'b0000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1})
      $display("FAIL illegal_outputs: got %b want 1100000000000000001", observed());
    else n_pass++;
    @(negedge clk);
    #1;
    exp_cnt = exp_cnt + 32'd1;
    n_chk++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== exp_cnt)
      $display("FAIL illegal_recover: state %0d cnt %0d want state 0 cnt %0d", bus.state, bus.instr_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    capture(6'b100011, 6'b000000, 1'b0, 4);
    n_chk++;
    if (obs_q[3][18:16] !== 3'd3) $display("FAIL midreset_in_mem: got state %0d want 3", obs_q[3][18:16]);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.state !== 3'd0 || {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we, bus.instr_done} !== 5'b00000)
      $display("FAIL midreset_abort: state %0d we %b want state 0 we 00000", bus.state,
               {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we, bus.instr_done});
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.state !== 3'd0 || bus.reg_we !== 1'b0 || bus.instr_cnt !== 32'd0)
      $display("FAIL midreset_hold: state %0d reg_we %b cnt %0d want 0 0 0", bus.state, bus.reg_we, bus.instr_cnt);
    else n_pass++;
    @(negedge clk);
    #1;
    reset = 1'b1;
    exp_cnt = 32'd0;
    run_checked("post_reset_ori", 6'b001101, 6'b000000, 1'b0);
  endtask

  task automatic test_wrap();
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    #1;
    exp_cnt = 32'hFFFF_FFFF;
    n_chk++;
    if (bus.instr_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_preset: got %h want ffffffff", bus.instr_cnt);
    else n_pass++;
    run_checked("wrap_nop", 6'b000000, 6'b000000, 1'b0);
    n_chk++;
    if (exp_cnt !== 32'd0 || bus.instr_cnt !== 32'd0)
      $display("FAIL wrap_zero: got %h want 00000000", bus.instr_cnt);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ori();
    test_lw_sw();
    test_beq();
    test_jal();
    test_misc_ops();
    test_illegal_state();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on the rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port op, input, 6 bits: instruction bits [31:26] from the datapath IR.
REQ-004 The block SHALL have port funct, input, 6 bits: instruction bits [5:0] from the datapath IR.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU equal flag.
REQ-006 The block SHALL have outputs pc_we, ir_we, reg_we, mem_we, each 1 bit: datapath write enables.
REQ-007 The block SHALL have output alu_op, 3 bits, encoded as follows: 000 add, 001 sub, 010 or, 011 lui (B<<16).
REQ-008 The block SHALL have output alu_src_b, 1 bit: 0 selects rt, 1 selects the extended immediate.
REQ-009 The block SHALL have output reg_dst, 2 bits, encoded as follows: 00 rt, 01 rd, 10 $31.
REQ-010 The block SHALL have output wd_sel, 2 bits, encoded as follows: 00 ALU result, 01 memory data, 10 PC+4.
REQ-011 The block SHALL have output ext_op, 1 bit: 0 zero-extend, 1 sign-extend.
REQ-012 The block SHALL have output npc_sel, 2 bits, encoded as follows: 00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr).
REQ-013 The block SHALL have output state, 3 bits: current FSM state.
REQ-014 The block SHALL have output instr_done, 1 bit: one-cycle retire pulse.
REQ-015 The block SHALL have output instr_cnt, 32 bits: count of retired instructions.

Function
REQ-016 The FSM SHALL have states IF=0, ID=1, EX=2, MEM=3, WB=4; encodings 5-7 are illegal and SHALL transition to IF with all write enables 0.
REQ-017 Control outputs SHALL be combinational from state, op, funct and zero; state and instr_cnt SHALL be registered.
REQ-018 Decoded instructions SHALL be: addu (op 0, funct 100001), subu (op 0, funct 100011), jr (op 0, funct 001000), nop (op 0, funct 000000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011; every other op/funct pair SHALL execute as nop.
REQ-019 In IF: ir_we=1, pc_we=1, npc_sel=00; next state SHALL be ID.
REQ-020 In ID, j: pc_we=1, npc_sel=10; next state SHALL be IF.
REQ-021 In ID, jal: pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10; next state SHALL be IF.
REQ-022 In ID, jr: pc_we=1, npc_sel=11; next state SHALL be IF.
REQ-023 In ID, nop or unknown: no write enables; next state SHALL be IF.
REQ-024 In ID, all other decoded instructions SHALL go to EX.
REQ-025 ext_op SHALL be 1 for lw, sw and beq, and 0 otherwise; alu_src_b SHALL be 1 for ori, lui, lw and sw.
REQ-026 alu_op SHALL be: subu and beq -> 001, ori -> 010, lui -> 011, all others -> 000.
REQ-027 In EX, beq: pc_we=zero, npc_sel=01; next state SHALL be IF.
REQ-028 In EX, lw/sw SHALL go to MEM; addu, subu, ori and lui SHALL go to WB.
REQ-029 In MEM, sw: mem_we=1; next state SHALL be IF. In MEM, lw SHALL go to WB.
REQ-030 In WB: reg_we=1; reg_dst=01 for addu/subu and 00 otherwise; wd_sel=01 for lw and 00 otherwise; next state SHALL be IF.
REQ-031 Required cycles per instruction: j/jal/jr/nop 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
REQ-032 instr_done SHALL be 1 exactly in the final state cycle of each instruction, i.e. whenever the next state is IF (including from an illegal state).
REQ-033 instr_cnt SHALL increment by 1 on each clock edge where instr_done=1, wrapping from 0xFFFFFFFF to 0.
REQ-034 Write enables SHALL never be asserted outside the state and instruction combinations listed above.

Reset
REQ-035 While reset=0, asynchronously: state=IF, instr_cnt=0, and pc_we, ir_we, reg_we, mem_we and instr_done SHALL be forced to 0 regardless of state.
REQ-036 A reset asserted mid-instruction SHALL abort that instruction without performing any pending write.
REQ-037 After reset deasserts, the first rising edge SHALL begin execution in IF.

Verification
REQ-038 The bench SHALL cover: reset release, then ori (op 001101) held -> state sequence 0,1,2,4,0; reg_we=1 only in WB; ext_op=0; instr_cnt=1 after 4 cycles.
REQ-039 The bench SHALL cover: lw -> 5 cycles; wd_sel=01 and reg_dst=00 in WB; sw -> mem_we=1 only in MEM, 4 cycles, reg_we never 1.
REQ-040 The bench SHALL cover: beq with zero=1 -> pc_we=1 and npc_sel=01 in EX; with zero=0 -> pc_we=0 in EX; both take 3 cycles.
REQ-041 The bench SHALL cover: jal -> in ID, reg_we=1, reg_dst=10, wd_sel=10, pc_we=1, npc_sel=10, instr_done=1; 2 cycles total.
REQ-042 The bench SHALL cover: op 111111 -> nop in 2 cycles with no writes; an illegal state forced to 6 -> IF on the next edge.
REQ-043 The bench SHALL cover: reset asserted during lw in MEM -> state=0 immediately with no reg_we pulse; instr_cnt preset to 0xFFFFFFFF plus one retire -> 0.
